cond_exec_unit: RTL and testbench
=================================

# cond_exec_unit

Conditional-execution and flag-state block that consumes the ALU's `result`-side status (`ALUFlags`, ordered N,Z,C,V in bits 3..0) and the decoder's 4-bit condition field. It holds the architectural NZCV register, evaluates the condition for each issued instruction, and gates the register-, memory- and PC-write enables in one registered stage between execute and writeback. It also keeps saturating executed/skipped instruction counters for debug.

## Interface
- `CNT_W`, 16, width of the executed/skipped counters (saturating).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `valid`  in  1  an instruction is presented this cycle.
- `cond`  in  4  condition field.
- `alu_flags`  in  4  ALU status {N,Z,C,V} for the presented instruction.
- `flag_w`  in  2  flag write mask: [1] updates N,Z; [0] updates C,V.
- `pcs`  in  1  instruction writes PC.
- `reg_w`  in  1  instruction writes register file.
- `mem_w`  in  1  instruction writes memory.
- `no_write`  in  1  suppress register write (compare-type ops).
- `stall`  in  1  hold all state.
- `flush`  in  1  squash the presented instruction and the output stage.
- `valid_o`  out  1  output stage holds an instruction.
- `cond_ex`  out  1  registered condition result of that instruction.
- `pc_src`  out  1  gated PC write.
- `reg_write`  out  1  gated register write.
- `mem_write`  out  1  gated memory write.
- `flags`  out  4  current NZCV register.
- `exec_cnt`  out  CNT_W  instructions executed (condition true).
- `skip_cnt`  out  CNT_W  instructions skipped (condition false).

## Operation
- Condition evaluated combinationally against the current `flags` register (not `alu_flags`): 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F never, 0.
- Accepted instruction = `valid & !stall & !flush`. On accept, with `ce` = evaluated condition:
  - `valid_o`<=1, `cond_ex`<=ce, `pc_src`<=pcs&ce, `reg_write`<=reg_w&!no_write&ce, `mem_write`<=mem_w&ce.
  - if ce: N,Z <= alu_flags[3:2] when flag_w[1]; C,V <= alu_flags[1:0] when flag_w[0].
  - `exec_cnt`+1 if ce, else `skip_cnt`+1; each saturates at all-ones (no wrap).
- `valid`=0, no stall/flush: output stage cleared (`valid_o` and all gated enables <=0); flags and counters hold.
- `stall`=1 (no flush): every register holds, including output stage and flags.
- `flush`=1: priority over `stall` and `valid`; output stage cleared, flags and counters unchanged.
- Reset (`rst_n`=0 at an edge, priority over everything, including mid-stall): `flags`=0000, `valid_o`=`cond_ex`=`pc_src`=`reg_write`=`mem_write`=0, both counters 0.

## Timing
- Latency 1 cycle: instruction presented in cycle k appears on gated outputs in cycle k+1.
- Flags written at the end of cycle k are seen by the condition of the instruction presented in cycle k+1; back-to-back flag-set then conditional needs no bubble.
- An instruction never sees its own `alu_flags` in its own condition.
- `flags` output is the register value, no bypass.
- Throughput one instruction per cycle when `stall`=0.

## Test plan
- Reset: hold `rst_n`=0 with `valid`=1, cond=E, flag_w=11, alu_flags=1111 -> after edge, flags=0000, all outputs 0, counters 0.
- Flag set then use: cycle k cond=E, flag_w=11, alu_flags=0100; cycle k+1 cond=0 (EQ), reg_w=1 -> flags=0100 after k, reg_write=1, cond_ex=1 in cycle k+2; exec_cnt=2.
- Skip: flags=0000, cond=0, reg_w=1, mem_w=1, pcs=1, flag_w=11, alu_flags=1111 -> all gated enables 0, flags stay 0000, skip_cnt=1.
- Signed conditions: flags N=1,V=0 -> cond B (LT) executes, A (GE) skips, C (GT) skips; cond F always skips; `no_write`=1 with cond E -> reg_write=0, flags still update.
- Stall/flush: assert stall for 3 cycles with new `valid` inputs -> outputs and flags frozen; assert flush together with stall -> output stage 0 next cycle, counters unchanged.
- Saturation: preload by running 65535 executed instructions, then one more -> exec_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/cond_exec_unit.sv
// rtl/cond_exec_unit.sv - condition evaluation, NZCV register and gated write enables
module cond_exec_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             pcs,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             no_write,
  input  logic             stall,
  input  logic             flush,
  output logic             valid_o,
  output logic             cond_ex,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  logic [3:0]       flags_q, flags_d;
  logic             valid_q, valid_d;
  logic             cond_ex_q, cond_ex_d;
  logic             pc_src_q, pc_src_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_write_q, mem_write_d;
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

  logic flag_n, flag_z, flag_c, flag_v;
  logic ce;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Evaluate the condition field against the architectural flags only, so an
  // instruction never observes its own ALU status.
  always_comb begin
    ce = 1'b0;
    unique case (cond)
      4'h0: ce = flag_z;
      4'h1: ce = !flag_z;
      4'h2: ce = flag_c;
      4'h3: ce = !flag_c;
      4'h4: ce = flag_n;
      4'h5: ce = !flag_n;
      4'h6: ce = flag_v;
      4'h7: ce = !flag_v;
      4'h8: ce = flag_c && !flag_z;
      4'h9: ce = !flag_c || flag_z;
      4'hA: ce = (flag_n == flag_v);
      4'hB: ce = (flag_n != flag_v);
      4'hC: ce = !flag_z && (flag_n == flag_v);
      4'hD: ce = flag_z || (flag_n != flag_v);
      4'hE: ce = 1'b1;
      4'hF: ce = 1'b0;
      default: ce = 1'b0;
    endcase
  end

  // Next-state: flush beats stall beats valid; an idle cycle drains the output stage.
  always_comb begin
    flags_d     = flags_q;
    valid_d     = valid_q;
    cond_ex_d   = cond_ex_q;
    pc_src_d    = pc_src_q;
    reg_write_d = reg_write_q;
    mem_write_d = mem_write_q;
    exec_cnt_d  = exec_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    if (flush || (!stall && !valid)) begin
      valid_d     = 1'b0;
      cond_ex_d   = 1'b0;
      pc_src_d    = 1'b0;
      reg_write_d = 1'b0;
      mem_write_d = 1'b0;
    end else if (!stall) begin
      valid_d     = 1'b1;
      cond_ex_d   = ce;
      pc_src_d    = pcs && ce;
      reg_write_d = reg_w && !no_write && ce;
      mem_write_d = mem_w && ce;
      if (ce) begin
        if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
        if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
        if (exec_cnt_q != '1) exec_cnt_d = exec_cnt_q + 1'b1;
      end else begin
        if (skip_cnt_q != '1) skip_cnt_d = skip_cnt_q + 1'b1;
      end
    end
  end

  // State register with synchronous active-low reset taking priority over stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q     <= 4'b0000;
      valid_q     <= 1'b0;
      cond_ex_q   <= 1'b0;
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      exec_cnt_q  <= '0;
      skip_cnt_q  <= '0;
    end else begin
      flags_q     <= flags_d;
      valid_q     <= valid_d;
      cond_ex_q   <= cond_ex_d;
      pc_src_q    <= pc_src_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
      exec_cnt_q  <= exec_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
    end
  end

  assign valid_o   = valid_q;
  assign cond_ex   = cond_ex_q;
  assign pc_src    = pc_src_q;
  assign reg_write = reg_write_q;
  assign mem_write = mem_write_q;
  assign flags     = flags_q;
  assign exec_cnt  = exec_cnt_q;
  assign skip_cnt  = skip_cnt_q;

endmodule

// File: tb/tb_cond_exec_unit.sv
// tb/tb_cond_exec_unit.sv - vector table and scoreboard bench for cond_exec_unit
`timescale 1ns/1ps
module tb_cond_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n, valid, pcs, reg_w, mem_w, no_write, stall, flush;
  logic [3:0]  cond, alu_flags;
  logic [1:0]  flag_w;
  logic        valid_o, cond_ex, pc_src, reg_write, mem_write;
  logic [3:0]  flags;
  logic [15:0] exec_cnt, skip_cnt;

  always #5 clk = ~clk;

  cond_exec_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .cond(cond), .alu_flags(alu_flags),
    .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
    .stall(stall), .flush(flush), .valid_o(valid_o), .cond_ex(cond_ex),
    .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write), .flags(flags),
    .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
  );

  typedef struct {
    logic        r, va, st, fl;
    logic [3:0]  c, a;
    logic [1:0]  fw;
    logic        p, rw, mw, nw;
    logic [4:0]  eo;   // {valid_o, cond_ex, pc_src, reg_write, mem_write}
    logic [3:0]  ef;
    logic [15:0] ee, es;
  } vec_t;

  vec_t      tbl[$];
  logic [40:0] sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic r, va, st, fl, input logic [3:0] c, a,
                              input logic [1:0] fw, input logic p, rw, mw, nw,
                              input logic [4:0] eo, input logic [3:0] ef,
                              input int ee, es);
    vec_t v;
    v.r = r; v.va = va; v.st = st; v.fl = fl; v.c = c; v.a = a; v.fw = fw;
    v.p = p; v.rw = rw; v.mw = mw; v.nw = nw; v.eo = eo; v.ef = ef;
    v.ee = ee[15:0]; v.es = es[15:0];
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_n = v.r; valid = v.va; stall = v.st; flush = v.fl; cond = v.c;
    alu_flags = v.a; flag_w = v.fw; pcs = v.p; reg_w = v.rw; mem_w = v.mw;
    no_write = v.nw;
  endtask

  task automatic step(input string name, input vec_t v);
    logic [40:0] act, exp;
    drive(v);
    sb.push_back({v.eo, v.ef, v.ee, v.es});
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    act = {valid_o, cond_ex, pc_src, reg_write, mem_write, flags, exec_cnt, skip_cnt};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got vo/ce/pc/rw/mw=%b flags=%b exec=%h skip=%h, want %b %b %h %h",
               name, act[40:36], act[35:32], act[31:16], act[15:0],
               exp[40:36], exp[35:32], exp[31:16], exp[15:0]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, want finish before 1ms");
    $fatal(1);
  end

  initial begin
    //          r  va st fl cond  alu  fw  p  rw mw nw   eo        ef      ee  es
    tbl.push_back(mk(0, 1, 0, 0, 4'hE, 4'hF, 3, 0, 0, 0, 0, 5'b00000, 4'h0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4'hE, 4'h4, 3, 0, 0, 0, 0, 5'b11000, 4'h4, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 4'h0, 0, 0, 1, 0, 0, 5'b11010, 4'h4, 2, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'hE, 4'hF, 3, 1, 1, 1, 0, 5'b00000, 4'h4, 2, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4'hE, 4'h0, 3, 0, 0, 0, 0, 5'b11000, 4'h0, 3, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 4'hF, 3, 1, 1, 1, 0, 5'b10000, 4'h0, 3, 1));
    tbl.push_back(mk(1, 1, 0, 0, 4'hE, 4'h8, 3, 0, 0, 0, 0, 5'b11000, 4'h8, 4, 1));
    tbl.push_back(mk(1, 1, 0, 0, 4'hB, 4'h0, 0, 1, 1, 1, 0, 5'b11111, 4'h8, 5, 1));
    tbl.push_back(mk(1, 1, 0, 0, 4'hA, 4'h0, 0, 0, 1, 0, 0, 5'b10000, 4'h8, 5, 2));
    tbl.push_back(mk(1, 1, 0, 0, 4'hC, 4'h0, 0, 0, 1, 0, 0, 5'b10000, 4'h8, 5, 3));
    tbl.push_back(mk(1, 1, 0, 0, 4'hF, 4'h0, 3, 0, 1, 0, 0, 5'b10000, 4'h8, 5, 4));
    tbl.push_back(mk(1, 1, 0, 0, 4'hE, 4'h4, 2, 0, 1, 0, 1, 5'b11000, 4'h4, 6, 4));
    tbl.push_back(mk(1, 1, 0, 0, 4'h1, 4'h0, 0, 0, 0, 1, 0, 5'b10000, 4'h4, 6, 5));
    tbl.push_back(mk(1, 1, 0, 0, 4'h9, 4'h3, 1, 1, 0, 0, 0, 5'b11100, 4'h7, 7, 5));
    tbl.push_back(mk(1, 1, 0, 0, 4'h2, 4'h0, 0, 0, 0, 1, 0, 5'b11001, 4'h7, 8, 5));
    tbl.push_back(mk(1, 1, 0, 0, 4'h6, 4'h0, 0, 0, 0, 0, 0, 5'b11000, 4'h7, 9, 5));
    tbl.push_back(mk(1, 1, 0, 0, 4'h8, 4'h0, 0, 0, 0, 0, 0, 5'b10000, 4'h7, 9, 6));
    tbl.push_back(mk(1, 1, 0, 0, 4'hD, 4'h0, 0, 0, 0, 0, 0, 5'b11000, 4'h7, 10, 6));
    tbl.push_back(mk(1, 1, 0, 0, 4'h3, 4'h0, 0, 0, 0, 0, 0, 5'b10000, 4'h7, 10, 7));
    tbl.push_back(mk(1, 1, 0, 0, 4'h7, 4'h0, 0, 0, 0, 0, 0, 5'b10000, 4'h7, 10, 8));
    tbl.push_back(mk(1, 1, 0, 0, 4'h4, 4'h0, 0, 0, 0, 0, 0, 5'b10000, 4'h7, 10, 9));
    tbl.push_back(mk(1, 1, 0, 0, 4'h5, 4'h0, 0, 0, 1, 0, 0, 5'b11010, 4'h7, 11, 9));

    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

    // Stall for three cycles with fresh instructions: everything frozen.
    for (int i = 0; i < 3; i++)
      step($sformatf("stall%0d", i),
           mk(1, 1, 1, 0, 4'hE, 4'hF, 3, 1, 0, 1, 0, 5'b11010, 4'h7, 11, 9));
    step("flush_with_stall", mk(1, 1, 1, 1, 4'hE, 4'hF, 3, 1, 1, 1, 0, 5'b00000, 4'h7, 11, 9));
    step("flush_alone",      mk(1, 1, 0, 1, 4'hE, 4'hF, 3, 1, 1, 1, 0, 5'b00000, 4'h7, 11, 9));
    step("after_flush",      mk(1, 1, 0, 0, 4'hE, 4'hA, 3, 0, 0, 0, 0, 5'b11000, 4'hA, 12, 9));
    step("stall_hold",       mk(1, 1, 1, 0, 4'hE, 4'hF, 3, 0, 0, 0, 0, 5'b11000, 4'hA, 12, 9));
    step("reset_mid_stall",  mk(0, 1, 1, 0, 4'hE, 4'hF, 3, 0, 0, 0, 0, 5'b00000, 4'h0, 0, 0));

    // Preload the executed counter to all-ones at full throughput.
    drive(mk(1, 1, 0, 0, 4'hE, 4'h0, 0, 0, 0, 0, 0, 5'b0, 4'h0, 0, 0));
    repeat (65534) @(posedge clk);
    #1;
    step("sat_reach",   mk(1, 1, 0, 0, 4'hE, 4'h0, 0, 0, 0, 0, 0, 5'b11000, 4'h0, 65535, 0));
    step("sat_hold",    mk(1, 1, 0, 0, 4'hE, 4'h0, 0, 0, 0, 0, 0, 5'b11000, 4'h0, 65535, 0));
    step("sat_skip",    mk(1, 1, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0, 0, 5'b10000, 4'h0, 65535, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
